sw_test_status_tracker: RTL and testbench

//   Per-core tracker for the SW test status word that software writes during chip-level tests.

---
 rtl/sw_test_status_tracker.sv | 158 +++++++++++++++
 tb/tb_sw_test_status_tracker.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_test_status_tracker.sv
// Per-core tracker for the SW test status word: decodes writes into a lifecycle state,
// flags illegal transitions and stalled cores, and reduces all cores to done/pass flags.
module sw_test_status_tracker #(
    parameter int unsigned NumCores      = 2,
    parameter int unsigned StatusW       = 16,
    parameter int unsigned TimeoutW      = 32,
    parameter int unsigned TimeoutCycles = 1_000_000
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NumCores-1:0]         status_valid_i,
    input  logic [NumCores*StatusW-1:0] status_data_i,
    input  logic                        clear_i,
    output logic [NumCores*3-1:0]       state_o,
    output logic [NumCores-1:0]         err_illegal_o,
    output logic [NumCores-1:0]         timeout_o,
    output logic                        done_o,
    output logic                        all_passed_o
);

    typedef enum logic [2:0] {
        StUnderReset = 3'd0,
        StBooted     = 3'd1,
        StInRom      = 3'd2,
        StInTest     = 3'd3,
        StInWfi      = 3'd4,
        StPassed     = 3'd5,
        StFailed     = 3'd6
    } state_e;

    localparam bit                  WatchdogOn = (TimeoutCycles != 0);
    localparam logic [TimeoutW-1:0] ExpireAt   = WatchdogOn ? TimeoutW'(TimeoutCycles - 1) : '0;

    state_e              r_state      [NumCores];
    logic [TimeoutW-1:0] r_cnt        [NumCores];
    logic [NumCores-1:0] r_errIllegal;
    logic [NumCores-1:0] r_timeout;

    state_e              w_nextState  [NumCores];
    logic [TimeoutW-1:0] w_nextCnt    [NumCores];
    logic [NumCores-1:0] w_nextErr;
    logic [NumCores-1:0] w_nextTimeout;

    // A code is only recognised when every bit above the low 16 is zero.
    function automatic logic isKnown(input logic [StatusW-1:0] word);
        logic [StatusW-1:0] upper;
        upper       = word;
        upper[15:0] = '0;
        if (upper != '0) return 1'b0;
        case (word[15:0])
            16'h0000, 16'hb004, 16'hb090, 16'h4354,
            16'h1d1e, 16'h900d, 16'hbaad: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic state_e toState(input logic [15:0] code);
        case (code)
            16'h0000: return StUnderReset;
            16'hb004: return StBooted;
            16'hb090: return StInRom;
            16'h4354: return StInTest;
            16'h1d1e: return StInWfi;
            16'h900d: return StPassed;
            default:  return StFailed;
        endcase
    endfunction

    function automatic logic isLegal(input state_e cur, input state_e nxt);
        if (nxt == StFailed) return 1'b1;
        case (cur)
            StUnderReset: return nxt == StBooted;
            StBooted:     return nxt == StInRom;
            StInRom:      return (nxt == StInTest) || (nxt == StPassed);
            StInTest:     return (nxt == StInWfi)  || (nxt == StPassed);
            StInWfi:      return (nxt == StInTest) || (nxt == StPassed);
            default:      return 1'b0;
        endcase
    endfunction

    function automatic logic isTerminal(input state_e s);
        return (s == StPassed) || (s == StFailed);
    endfunction

    function automatic logic isCounting(input state_e s);
        return (s == StBooted) || (s == StInRom) || (s == StInTest);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NumCores; k++) begin
                r_state[k] <= StUnderReset;
                r_cnt[k]   <= '0;
            end
            r_errIllegal <= '0;
            r_timeout    <= '0;
        end else begin
            for (int k = 0; k < NumCores; k++) begin
                r_state[k] <= w_nextState[k];
                r_cnt[k]   <= w_nextCnt[k];
            end
            r_errIllegal <= w_nextErr;
            r_timeout    <= w_nextTimeout;
        end
    end

    // Clear beats writes, writes beat watchdog expiry, terminal states freeze everything.
    always_comb begin
        w_nextErr     = r_errIllegal;
        w_nextTimeout = r_timeout;
        for (int k = 0; k < NumCores; k++) begin
            w_nextState[k] = r_state[k];
            w_nextCnt[k]   = r_cnt[k];
            if (clear_i) begin
                w_nextState[k]   = StUnderReset;
                w_nextCnt[k]     = '0;
                w_nextErr[k]     = 1'b0;
                w_nextTimeout[k] = 1'b0;
            end else if (isTerminal(r_state[k])) begin
                w_nextState[k] = r_state[k];
            end else if (status_valid_i[k]) begin
                w_nextCnt[k] = '0;
                if (!isKnown(status_data_i[k*StatusW +: StatusW])) begin
                    w_nextState[k] = StFailed;
                    w_nextErr[k]   = 1'b1;
                end else if (toState(status_data_i[k*StatusW +: 16]) == r_state[k]) begin
                    w_nextState[k] = r_state[k];
                end else if (isLegal(r_state[k], toState(status_data_i[k*StatusW +: 16]))) begin
                    w_nextState[k] = toState(status_data_i[k*StatusW +: 16]);
                end else begin
                    w_nextState[k] = StFailed;
                    w_nextErr[k]   = 1'b1;
                end
            end else if (isCounting(r_state[k])) begin
                if (WatchdogOn && (r_cnt[k] == ExpireAt)) begin
                    w_nextState[k]   = StFailed;
                    w_nextTimeout[k] = 1'b1;
                end else if (r_cnt[k] != '1) begin
                    w_nextCnt[k] = r_cnt[k] + TimeoutW'(1);
                end
            end
        end
    end

    always_comb begin
        state_o       = '0;
        done_o        = 1'b1;
        all_passed_o  = 1'b1;
        err_illegal_o = r_errIllegal;
        timeout_o     = r_timeout;
        for (int k = 0; k < NumCores; k++) begin
            state_o[k*3 +: 3] = r_state[k];
            done_o            = done_o & isTerminal(r_state[k]);
            all_passed_o      = all_passed_o & (r_state[k] == StPassed);
        end
    end

endmodule

// File: tb/tb_sw_test_status_tracker.sv
// Self-checking bench for sw_test_status_tracker: directed lifecycle scenarios followed by
// randomized writes/clears, all compared every cycle against a table-driven reference model.
module tb_sw_test_status_tracker;

    localparam int NumCores      = 2;
    localparam int StatusW       = 20;
    localparam int TimeoutW      = 16;
    localparam int TimeoutCycles = 10;

    logic                        clk = 1'b0;
    logic                        rstN;
    logic [NumCores-1:0]         statusValid;
    logic [NumCores*StatusW-1:0] statusData;
    logic                        clear;
    logic [NumCores*3-1:0]       stateOut;
    logic [NumCores-1:0]         errIllegal;
    logic [NumCores-1:0]         timeoutOut;
    logic                        done;
    logic                        allPassed;

    int checkCount = 0;
    int passCount  = 0;

    int mState [NumCores];
    int mIdle  [NumCores];
    bit mErr   [NumCores];
    bit mTo    [NumCores];
    int codeTab [7];
    bit legalTab [7][7];

    sw_test_status_tracker #(
        .NumCores     (NumCores),
        .StatusW      (StatusW),
        .TimeoutW     (TimeoutW),
        .TimeoutCycles(TimeoutCycles)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rstN),
        .status_valid_i(statusValid),
        .status_data_i (statusData),
        .clear_i       (clear),
        .state_o       (stateOut),
        .err_illegal_o (errIllegal),
        .timeout_o     (timeoutOut),
        .done_o        (done),
        .all_passed_o  (allPassed)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    endtask

    // Index of a status word in the code table, or -1 when it is not a recognised code.
    function automatic int lookupCode(input logic [StatusW-1:0] w);
        logic [StatusW-1:0] upper;
        upper       = w;
        upper[15:0] = '0;
        if (upper != '0) return -1;
        for (int i = 0; i < 7; i++) if (codeTab[i] == int'(w[15:0])) return i;
        return -1;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < NumCores; k++) begin
            mState[k] = 0;
            mIdle[k]  = 0;
            mErr[k]   = 1'b0;
            mTo[k]    = 1'b0;
        end
    endtask

    task automatic modelUpdate(input logic [NumCores-1:0] v, input logic [NumCores*StatusW-1:0] d, input logic clr);
        int st;
        for (int k = 0; k < NumCores; k++) begin
            if (clr) begin
                mState[k] = 0; mIdle[k] = 0; mErr[k] = 1'b0; mTo[k] = 1'b0;
            end else if (mState[k] >= 5) begin
                mState[k] = mState[k];
            end else if (v[k]) begin
                mIdle[k] = 0;
                st = lookupCode(d[k*StatusW +: StatusW]);
                if (st < 0 || (st != mState[k] && !legalTab[mState[k]][st])) begin
                    mState[k] = 6;
                    mErr[k]   = 1'b1;
                end else begin
                    mState[k] = st;
                end
            end else if (mState[k] >= 1 && mState[k] <= 3) begin
                if (mIdle[k] + 1 >= TimeoutCycles) begin
                    mState[k] = 6;
                    mTo[k]    = 1'b1;
                end else begin
                    mIdle[k]++;
                end
            end
        end
    endtask

    task automatic checkModel();
        logic [NumCores*3-1:0] expState;
        logic [NumCores-1:0]   expErr;
        logic [NumCores-1:0]   expTo;
        logic                  expDone;
        logic                  expAll;
        expDone = 1'b1;
        expAll  = 1'b1;
        for (int k = 0; k < NumCores; k++) begin
            expState[k*3 +: 3] = 3'(mState[k]);
            expErr[k]          = mErr[k];
            expTo[k]           = mTo[k];
            expDone            = expDone & (mState[k] >= 5);
            expAll             = expAll & (mState[k] == 5);
        end
        checkOutput("state_o", 64'(stateOut), 64'(expState));
        checkOutput("err_illegal_o", 64'(errIllegal), 64'(expErr));
        checkOutput("timeout_o", 64'(timeoutOut), 64'(expTo));
        checkOutput("done_o", 64'(done), 64'(expDone));
        checkOutput("all_passed_o", 64'(allPassed), 64'(expAll));
    endtask

    // One clock: drive at the falling edge, model the rising edge, compare at the next falling edge.
    task automatic applyStimulus(input logic [NumCores-1:0] v, input logic [NumCores*StatusW-1:0] d, input logic clr);
        statusValid = v;
        statusData  = d;
        clear       = clr;
        @(posedge clk);
        modelUpdate(v, d, clr);
        @(negedge clk);
        statusValid = '0;
        clear       = 1'b0;
        checkModel();
    endtask

    function automatic logic [NumCores*StatusW-1:0] slot(input int core, input logic [StatusW-1:0] w);
        logic [NumCores*StatusW-1:0] r;
        r = '0;
        r[core*StatusW +: StatusW] = w;
        return r;
    endfunction

    task automatic writeCore(input int core, input logic [StatusW-1:0] w);
        logic [NumCores-1:0] v;
        v       = '0;
        v[core] = 1'b1;
        applyStimulus(v, slot(core, w), 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus('0, '0, 1'b0);
    endtask

    task automatic clearAll();
        applyStimulus('0, '0, 1'b1);
    endtask

    task automatic toInTest(input int core);
        writeCore(core, 20'hb004);
        writeCore(core, 20'hb090);
        writeCore(core, 20'h4354);
    endtask

    initial begin
        logic [NumCores-1:0]         rv;
        logic [NumCores*StatusW-1:0] rd;
        logic [StatusW-1:0]          w;
        int                          q[$];
        int                          pick;

        codeTab = '{32'h0000, 32'hb004, 32'hb090, 32'h4354, 32'h1d1e, 32'h900d, 32'hbaad};
        for (int s = 0; s < 7; s++) for (int t = 0; t < 7; t++) legalTab[s][t] = 1'b0;
        for (int s = 0; s < 5; s++) legalTab[s][6] = 1'b1;
        legalTab[0][1] = 1'b1; legalTab[1][2] = 1'b1; legalTab[2][3] = 1'b1;
        legalTab[3][4] = 1'b1; legalTab[4][3] = 1'b1;
        legalTab[2][5] = 1'b1; legalTab[3][5] = 1'b1; legalTab[4][5] = 1'b1;

        rstN        = 1'b0;
        statusValid = '0;
        statusData  = '0;
        clear       = 1'b0;
        modelReset();
        @(negedge clk);
        checkOutput("reset state_o", 64'(stateOut), 64'd0);
        checkOutput("reset done_o", 64'(done), 64'd0);
        checkOutput("reset all_passed_o", 64'(allPassed), 64'd0);
        checkModel();
        @(negedge clk);
        rstN = 1'b1;

        $display("[TB] core0 walks to PASSED");
        toInTest(0);
        writeCore(0, 20'h900d);
        checkOutput("t1 state0", 64'(stateOut[2:0]), 64'd5);
        checkOutput("t1 done_o", 64'(done), 64'd0);

        $display("[TB] both cores PASSED, late baad ignored");
        toInTest(1);
        writeCore(1, 20'h900d);
        checkOutput("t2 done_o", 64'(done), 64'd1);
        checkOutput("t2 all_passed_o", 64'(allPassed), 64'd1);
        writeCore(1, 20'hbaad);
        checkOutput("t2 all_passed_o after baad", 64'(allPassed), 64'd1);
        checkOutput("t2 err after baad", 64'(errIllegal), 64'd0);

        $display("[TB] illegal transitions and unknown codes");
        clearAll();
        checkOutput("t3 cleared state_o", 64'(stateOut), 64'd0);
        writeCore(0, 20'hb004);
        writeCore(0, 20'h4354);
        checkOutput("t3 skip rom state0", 64'(stateOut[2:0]), 64'd6);
        checkOutput("t3 skip rom err0", 64'(errIllegal[0]), 64'd1);
        clearAll();
        writeCore(0, 20'hb004);
        writeCore(0, 20'h1234);
        checkOutput("t3 unknown state0", 64'(stateOut[2:0]), 64'd6);
        checkOutput("t3 unknown err0", 64'(errIllegal[0]), 64'd1);
        clearAll();
        writeCore(1, 20'h1b004);
        checkOutput("t3 upper bits state1", 64'(stateOut[5:3]), 64'd6);
        checkOutput("t3 upper bits err1", 64'(errIllegal[1]), 64'd1);

        $display("[TB] watchdog expiry and last-moment rewrite");
        clearAll();
        toInTest(0);
        idle(TimeoutCycles - 1);
        checkOutput("t4 before expiry state0", 64'(stateOut[2:0]), 64'd3);
        checkOutput("t4 before expiry timeout0", 64'(timeoutOut[0]), 64'd0);
        idle(1);
        checkOutput("t4 expiry state0", 64'(stateOut[2:0]), 64'd6);
        checkOutput("t4 expiry timeout0", 64'(timeoutOut[0]), 64'd1);
        clearAll();
        toInTest(0);
        idle(TimeoutCycles - 1);
        writeCore(0, 20'h4354);
        checkOutput("t4 rewrite state0", 64'(stateOut[2:0]), 64'd3);
        checkOutput("t4 rewrite timeout0", 64'(timeoutOut[0]), 64'd0);
        idle(TimeoutCycles - 1);
        checkOutput("t4 reloaded state0", 64'(stateOut[2:0]), 64'd3);

        $display("[TB] long WFI does not time out");
        clearAll();
        toInTest(0);
        writeCore(0, 20'h1d1e);
        idle(50);
        checkOutput("t5 wfi state0", 64'(stateOut[2:0]), 64'd4);
        checkOutput("t5 wfi timeout0", 64'(timeoutOut[0]), 64'd0);
        writeCore(0, 20'h4354);
        checkOutput("t5 back to test", 64'(stateOut[2:0]), 64'd3);

        $display("[TB] clear beats a simultaneous write");
        writeCore(1, 20'h1234);
        applyStimulus(2'b01, slot(0, 20'h900d), 1'b1);
        checkOutput("t6 state_o", 64'(stateOut), 64'd0);
        checkOutput("t6 err_illegal_o", 64'(errIllegal), 64'd0);
        checkOutput("t6 timeout_o", 64'(timeoutOut), 64'd0);

        $display("[TB] asynchronous reset mid-test");
        toInTest(0);
        writeCore(1, 20'hbaad);
        #2;
        rstN = 1'b0;
        #1;
        modelReset();
        checkOutput("t7 state_o", 64'(stateOut), 64'd0);
        checkOutput("t7 err_illegal_o", 64'(errIllegal), 64'd0);
        checkOutput("t7 timeout_o", 64'(timeoutOut), 64'd0);
        checkOutput("t7 done_o", 64'(done), 64'd0);
        @(negedge clk);
        rstN = 1'b1;
        checkModel();

        $display("[TB] randomized traffic");
        for (int cyc = 0; cyc < 2000; cyc++) begin
            rv = '0;
            rd = '0;
            for (int k = 0; k < NumCores; k++) begin
                if ($urandom_range(99) < 25) begin
                    rv[k] = 1'b1;
                    pick  = int'($urandom_range(9));
                    if (pick < 5) begin
                        q.delete();
                        for (int t = 0; t < 6; t++)
                            if (mState[k] < 7 && legalTab[mState[k]][t]) q.push_back(t);
                        w = (q.size() == 0) ? StatusW'(codeTab[mState[k] % 7])
                                            : StatusW'(codeTab[q[$urandom_range(q.size() - 1)]]);
                    end else if (pick < 8) begin
                        w = StatusW'(codeTab[$urandom_range(6)]);
                    end else if (pick == 8) begin
                        w = StatusW'($urandom_range(16'hffff));
                    end else begin
                        w = StatusW'(codeTab[$urandom_range(6)]) | StatusW'(32'h10000 << $urandom_range(3));
                    end
                    rd[k*StatusW +: StatusW] = w;
                end
            end
            if ($urandom_range(99) < 2 || (mState[0] >= 5 && mState[1] >= 5 && $urandom_range(99) < 20))
                applyStimulus(rv, rd, 1'b1);
            else
                applyStimulus(rv, rd, 1'b0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
